// File: rtl/banco_reg_contextos.sv
// Banked register file with one bank per process context, PC shadowing,
// region-dependent link register and a save/clear/switch context FSM.
module banco_reg_contextos #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int NUM_CTX     = 4,
    parameter int CTX_W       = 2,
    parameter int LIMITE_KERN = 3000,
    parameter int RA_KERN     = 30,
    parameter int RA_USER     = 16,
    parameter int REG_PC      = 11,
    parameter int REG_SAVE    = 10,
    parameter int REG_PROG    = 24,
    parameter int REG_PREEMP  = 29
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] reg1,
    input  logic [ADDR_W-1:0] reg2,
    input  logic [ADDR_W-1:0] reg3,
    output logic [DATA_W-1:0] dado1,
    output logic [DATA_W-1:0] dado2,
    output logic [DATA_W-1:0] dado3,
    input  logic [ADDR_W-1:0] reg_escrita,
    input  logic [DATA_W-1:0] dados_escrita,
    input  logic              escreve_reg,
    input  logic              jal,
    input  logic              save,
    input  logic [DATA_W-1:0] endereco_pc,
    input  logic              troca_req,
    input  logic [CTX_W-1:0]  troca_ctx,
    input  logic              troca_limpa,
    output logic              troca_ocupado,
    output logic              troca_pronto,
    output logic              troca_erro,
    output logic [CTX_W-1:0]  ctx_ativo,
    output logic [DATA_W-1:0] pc_retorno,
    output logic [DATA_W-1:0] pc_atual,
    output logic [DATA_W-1:0] prog_atual,
    output logic [DATA_W-1:0] preempcao
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CI_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam logic [CTX_W:0] NUM_L = (CTX_W + 1)'(NUM_CTX);

    typedef enum logic [1:0] {OCIOSO, SALVA, LIMPA, TROCA} estado_t;

    estado_t           state_reg, state_next;
    logic [DATA_W-1:0] banco_reg    [NUM_CTX][DEPTH];
    logic [DATA_W-1:0] saved_pc_reg [NUM_CTX];
    logic [CTX_W-1:0]  ctx_ativo_reg, alvo_reg;
    logic              limpa_reg, pronto_reg, erro_reg;
    logic [ADDR_W-1:0] cont_reg;
    logic              aceita, rejeita;

    logic [CI_W-1:0]   ativo_idx, alvo_idx;
    logic [ADDR_W-1:0] reg_link;
    logic [ADDR_W-1:0] rd_addr [3];
    logic [DATA_W-1:0] rd_dado [3];

    assign ativo_idx = ctx_ativo_reg[CI_W-1:0];
    assign alvo_idx  = alvo_reg[CI_W-1:0];

    assign rd_addr[0] = reg1;
    assign rd_addr[1] = reg2;
    assign rd_addr[2] = reg3;

    // Register 0 is hardwired to zero regardless of array contents.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_leitura
            assign rd_dado[gi] = (rd_addr[gi] == '0) ? '0 : banco_reg[ativo_idx][rd_addr[gi]];
        end
    endgenerate

    assign dado1 = rd_dado[0];
    assign dado2 = rd_dado[1];
    assign dado3 = rd_dado[2];

    assign pc_atual      = banco_reg[ativo_idx][ADDR_W'(REG_PC)];
    assign prog_atual    = banco_reg[ativo_idx][ADDR_W'(REG_PROG)];
    assign preempcao     = banco_reg[ativo_idx][ADDR_W'(REG_PREEMP)];
    assign pc_retorno    = saved_pc_reg[ativo_idx];
    assign ctx_ativo     = ctx_ativo_reg;
    assign troca_ocupado = (state_reg != OCIOSO);
    assign troca_pronto  = pronto_reg;
    assign troca_erro    = erro_reg;

    assign reg_link = (pc_atual < DATA_W'(LIMITE_KERN)) ? ADDR_W'(RA_KERN) : ADDR_W'(RA_USER);

    always_comb begin
        state_next = state_reg;
        aceita     = 1'b0;
        rejeita    = 1'b0;
        case (state_reg)
            OCIOSO: begin
                if (troca_req) begin
                    if ({1'b0, troca_ctx} < NUM_L) begin
                        aceita     = 1'b1;
                        state_next = SALVA;
                    end else begin
                        rejeita = 1'b1;
                    end
                end
            end
            SALVA:   state_next = limpa_reg ? LIMPA : TROCA;
            LIMPA:   if (cont_reg == ADDR_W'(DEPTH - 1)) state_next = TROCA;
            TROCA:   state_next = OCIOSO;
            default: state_next = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= OCIOSO;
            alvo_reg      <= '0;
            limpa_reg     <= 1'b0;
            cont_reg      <= '0;
            ctx_ativo_reg <= '0;
            pronto_reg    <= 1'b0;
            erro_reg      <= 1'b0;
            for (int c = 0; c < NUM_CTX; c++) saved_pc_reg[c] <= '0;
        end else begin
            state_reg  <= state_next;
            pronto_reg <= (state_reg == TROCA);
            erro_reg   <= rejeita;
            case (state_reg)
                OCIOSO: begin
                    if (aceita) begin
                        alvo_reg  <= troca_ctx;
                        limpa_reg <= troca_limpa;
                    end
                end
                SALVA: begin
                    saved_pc_reg[ativo_idx] <= endereco_pc;
                    cont_reg                <= ADDR_W'(1);
                end
                LIMPA:   cont_reg <= cont_reg + ADDR_W'(1);
                TROCA:   ctx_ativo_reg <= alvo_reg;
                default: ;
            endcase
        end
    end

    // Idle writes are ordered so that later assignments win on a shared index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CTX; c++)
                for (int r = 0; r < DEPTH; r++)
                    banco_reg[c][r] <= '0;
        end else if (state_reg == OCIOSO) begin
            if (escreve_reg && reg_escrita != '0)
                banco_reg[ativo_idx][reg_escrita] <= dados_escrita;
            if (jal)
                banco_reg[ativo_idx][reg_link] <= dados_escrita;
            banco_reg[ativo_idx][ADDR_W'(REG_PC)] <= endereco_pc;
            if (save)
                banco_reg[ativo_idx][ADDR_W'(REG_SAVE)] <= endereco_pc;
        end else if (state_reg == LIMPA) begin
            banco_reg[alvo_idx][cont_reg] <= '0;
        end
    end
endmodule

// File: tb/tb_banco_reg_contextos.sv
// Directed and randomized checks of banco_reg_contextos against a
// transaction-level model of banks, saved PCs and switch timing.
module tb_banco_reg_contextos;
    localparam int NCTX = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  reg1 = '0, reg2 = '0, reg3 = '0, reg_escrita = '0;
    logic [31:0] dado1, dado2, dado3, dados_escrita = '0, endereco_pc = '0;
    logic        escreve_reg = 1'b0, jal = 1'b0, save = 1'b0;
    logic        troca_req = 1'b0, troca_limpa = 1'b0;
    logic [2:0]  troca_ctx = '0;
    logic        troca_ocupado, troca_pronto, troca_erro;
    logic [2:0]  ctx_ativo;
    logic [31:0] pc_retorno, pc_atual, prog_atual, preempcao;

    banco_reg_contextos #(.NUM_CTX(NCTX), .CTX_W(3)) dut (
        .clock(clock), .reset(reset),
        .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .dado1(dado1), .dado2(dado2), .dado3(dado3),
        .reg_escrita(reg_escrita), .dados_escrita(dados_escrita),
        .escreve_reg(escreve_reg), .jal(jal), .save(save),
        .endereco_pc(endereco_pc),
        .troca_req(troca_req), .troca_ctx(troca_ctx), .troca_limpa(troca_limpa),
        .troca_ocupado(troca_ocupado), .troca_pronto(troca_pronto), .troca_erro(troca_erro),
        .ctx_ativo(ctx_ativo), .pc_retorno(pc_retorno),
        .pc_atual(pc_atual), .prog_atual(prog_atual), .preempcao(preempcao)
    );

    always #5 clock = ~clock;

    // Reference model: register contents, saved PCs and a switch in flight
    // described only by its remaining duration and final effects.
    logic [31:0] m_bank [NCTX][32];
    logic [31:0] m_saved [NCTX];
    int          m_ctx, m_busy, m_tgt, m_limpa, m_first;
    logic        exp_pronto, exp_erro;
    int          checks = 0, errors = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : m_bank[m_ctx][a];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCTX; c++) begin
            m_saved[c] = '0;
            for (int r = 0; r < 32; r++) m_bank[c][r] = '0;
        end
        m_ctx = 0; m_busy = 0; m_tgt = 0; m_limpa = 0; m_first = 0;
    endtask

    task automatic compare_all();
        chk("ocupado", 32'(troca_ocupado), 32'(m_busy != 0));
        chk("pronto", 32'(troca_pronto), 32'(exp_pronto));
        chk("erro", 32'(troca_erro), 32'(exp_erro));
        chk("ctx_ativo", 32'(ctx_ativo), 32'(m_ctx));
        chk("pc_retorno", pc_retorno, m_saved[m_ctx]);
        if (m_busy == 0) begin
            chk("dado1", dado1, m_rd(reg1));
            chk("dado2", dado2, m_rd(reg2));
            chk("dado3", dado3, m_rd(reg3));
            chk("pc_atual", pc_atual, m_bank[m_ctx][11]);
            chk("prog_atual", prog_atual, m_bank[m_ctx][24]);
            chk("preempcao", preempcao, m_bank[m_ctx][29]);
        end
    endtask

    // One clock edge: predict from current inputs, clock, then compare.
    task automatic tick();
        int link;
        exp_pronto = 1'b0;
        exp_erro   = 1'b0;
        if (m_busy == 0) begin
            link = (m_bank[m_ctx][11] < 32'd3000) ? 30 : 16;
            if (escreve_reg && reg_escrita != 5'd0) m_bank[m_ctx][reg_escrita] = dados_escrita;
            if (jal) m_bank[m_ctx][link] = dados_escrita;
            m_bank[m_ctx][11] = endereco_pc;
            if (save) m_bank[m_ctx][10] = endereco_pc;
            if (troca_req) begin
                if (int'(troca_ctx) < NCTX) begin
                    m_tgt = int'(troca_ctx); m_limpa = int'(troca_limpa);
                    m_busy = troca_limpa ? 33 : 2; m_first = 1;
                end else begin
                    exp_erro = 1'b1;
                end
            end
        end else begin
            if (m_first != 0) begin
                m_saved[m_ctx] = endereco_pc;
                m_first = 0;
            end
            m_busy--;
            if (m_busy == 0) begin
                if (m_limpa != 0) for (int r = 1; r < 32; r++) m_bank[m_tgt][r] = '0;
                m_ctx = m_tgt;
                exp_pronto = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        compare_all();
        $display("cyc %0d ctx %0d busy %0d pronto %0b erro %0b pc_atual %h", cyc, ctx_ativo,
                 troca_ocupado, troca_pronto, troca_erro, pc_atual);
    endtask

    task automatic clear_inputs();
        escreve_reg = 0; jal = 0; save = 0; troca_req = 0; troca_limpa = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dado1"}, dado1, 32'd0);
        chk({tag, "_pc_atual"}, pc_atual, 32'd0);
        chk({tag, "_pc_retorno"}, pc_retorno, 32'd0);
        chk({tag, "_ctx"}, 32'(ctx_ativo), 32'd0);
        chk({tag, "_ocupado"}, 32'(troca_ocupado), 32'd0);
        chk({tag, "_pronto"}, 32'(troca_pronto), 32'd0);
    endtask

    task automatic switch_to(input int c, input logic lim);
        troca_req = 1; troca_ctx = 3'(c); troca_limpa = lim;
        tick();
        clear_inputs();
        for (int k = 0; k < 40 && troca_ocupado; k++) tick();
        chk("switch_done", 32'(troca_ocupado), 32'd0);
    endtask

    int busy_cnt;

    initial begin
        model_reset();
        reg1 = 5'd5; reg2 = 5'd7; reg3 = 5'd0;
        endereco_pc = 32'h1234;
        reset = 1; #1;
        check_reset_outputs("reset");
        @(posedge clock); #1;
        reset = 0;
        $display("reset released");

        // Basic write and register-zero behaviour
        escreve_reg = 1; reg_escrita = 5; dados_escrita = 32'hDEADBEEF; reg1 = 5;
        tick();
        chk("t1_dado1", dado1, 32'hDEADBEEF);
        reg_escrita = 0; dados_escrita = 32'h12345678; reg2 = 0;
        tick();
        escreve_reg = 0;
        chk("t1_reg0", dado2, 32'd0);

        // Link register selection by PC region
        endereco_pc = 100; tick();
        jal = 1; dados_escrita = 32'h44; reg1 = 30; tick(); jal = 0;
        chk("t2_ra_kern", dado1, 32'h44);
        endereco_pc = 4000; tick();
        jal = 1; dados_escrita = 32'h55; reg2 = 16; tick(); jal = 0;
        chk("t2_ra_user", dado2, 32'h55);
        chk("t2_ra_kern_kept", dado1, 32'h44);

        // Switch 0 -> 2 without clear, then back
        endereco_pc = 32'h200;
        troca_req = 1; troca_ctx = 2; troca_limpa = 0; tick(); clear_inputs();
        chk("t3_busy", 32'(troca_ocupado), 32'd1);
        tick();
        tick();
        chk("t3_ctx2", 32'(ctx_ativo), 32'd2);
        chk("t3_pronto", 32'(troca_pronto), 32'd1);
        tick();
        chk("t3_pronto_pulse", 32'(troca_pronto), 32'd0);
        for (int r = 1; r < 32; r += 3) begin
            escreve_reg = 1; reg_escrita = 5'(r); dados_escrita = 32'hA000_0000 + 32'(r); tick();
        end
        escreve_reg = 0;
        endereco_pc = 32'h300;
        switch_to(0, 0);
        reg1 = 5;
        tick();
        chk("t3_pc_retorno", pc_retorno, 32'h200);
        chk("t3_ctx0_reg5", dado1, 32'hDEADBEEF);

        // Clearing switch into filled ctx2; writes while busy are dropped
        troca_req = 1; troca_ctx = 2; troca_limpa = 1; tick(); clear_inputs();
        busy_cnt = 0;
        escreve_reg = 1; reg_escrita = 7; dados_escrita = 32'hBAD0BAD0;
        for (int k = 0; k < 100 && troca_ocupado; k++) begin
            busy_cnt++;
            tick();
        end
        escreve_reg = 0;
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd33);
        chk("t4_ctx", 32'(ctx_ativo), 32'd2);
        endereco_pc = 32'h777;
        for (int r = 0; r < 32; r++) begin
            reg1 = 5'(r); tick();
            chk("t4_sweep", dado1, (r == 11) ? 32'h777 : 32'd0);
        end

        // Invalid target and requests while busy
        troca_req = 1; troca_ctx = 5; tick(); clear_inputs();
        chk("t5_erro", 32'(troca_erro), 32'd1);
        chk("t5_idle", 32'(troca_ocupado), 32'd0);
        chk("t5_ctx", 32'(ctx_ativo), 32'd2);
        tick();
        chk("t5_erro_pulse", 32'(troca_erro), 32'd0);
        troca_req = 1; troca_ctx = 1; tick();
        troca_ctx = 3; tick();
        troca_ctx = 6; tick();
        clear_inputs();
        chk("t5_ignored_ctx", 32'(ctx_ativo), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            reg1 = 5'($urandom); reg2 = 5'($urandom); reg3 = 5'($urandom);
            reg_escrita = 5'($urandom); dados_escrita = $urandom;
            escreve_reg = ($urandom_range(0, 1) == 1);
            jal  = ($urandom_range(0, 3) == 0);
            save = ($urandom_range(0, 3) == 0);
            endereco_pc = $urandom_range(0, 6000);
            troca_req = ($urandom_range(0, 15) == 0);
            troca_ctx = 3'($urandom_range(0, 7));
            troca_limpa = ($urandom_range(0, 2) == 0);
            tick();
        end
        clear_inputs();
        for (int k = 0; k < 40 && troca_ocupado; k++) tick();

        // Asynchronous reset in the middle of a clearing switch
        troca_req = 1; troca_ctx = 3'((m_ctx + 1) % NCTX); troca_limpa = 1; tick(); clear_inputs();
        for (int k = 0; k < 10; k++) tick();
        chk("t6_in_limpa", 32'(troca_ocupado), 32'd1);
        #2 reset = 1; #1;
        model_reset();
        check_reset_outputs("t6_reset");
        @(posedge clock); #1;
        check_reset_outputs("t6_hold");
        reset = 0;
        endereco_pc = 32'h0;
        for (int c = 0; c < NCTX; c++) begin
            for (int r = 0; r < 32; r += 3) begin
                reg1 = 5'(r); reg2 = 5'(r + 1); reg3 = 5'(r + 2); tick();
            end
            switch_to((c + 1) % NCTX, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
